max7219_refresh_ctrl: RTL and testbench
=======================================

Name: max7219_refresh_ctrl

Overview:
- Sequences the MAX7219 serial shifter: power-up register initialisation, then periodic or on-demand refresh of the 8 digit registers from an internal 8x8-bit frame buffer.
- Also performs runtime intensity updates.
- Sits between application logic (byte-wide digit writes) and the 16-bit word handshake of the shifter.

Parameters:
- DECODE_MODE, 8'h00, value written to register 0x9 during init.
- INIT_INTENSITY, 4'h8, intensity written to register 0xA during init.
- SCAN_LIMIT, 3'd7, value written to register 0xB during init.
- REFRESH_CYCLES, 1000000, clock cycles from end of one refresh to forced start of the next; must be >= 1.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- wr_en  input  1  frame buffer write strobe.
- wr_addr  input  3  digit index 0..7, maps to MAX7219 register wr_addr+1.
- wr_data  input  8  segment byte.
- int_wr  input  1  intensity update strobe.
- int_value  input  4  new intensity.
- shift_data  output  16  word to shifter: {4'h0, reg_addr[3:0], value[7:0]}.
- shift_valid  output  1  word valid.
- shift_ack  input  1  one-cycle pulse from shifter: word accepted.
- init_done  output  1  high once the init sequence has completed.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, reset_n low):
  - shift_valid=0, shift_data=0, init_done=0, busy=1.
  - Frame buffer cleared to 0, dirty=1, int_pending=0, timer=0.
  - state=INIT, index=0.
- Handshake:
  - A word is registered into shift_data together with shift_valid=1.
  - shift_data and shift_valid are held stable until shift_ack is sampled high.
  - On the cycle shift_ack is sampled high:
    - If another word follows, shift_data loads it with shift_valid kept at 1.
    - Otherwise shift_valid drops to 0 on the next edge.
  - At most one word is outstanding. A shift_ack with shift_valid=0 is ignored.
- INIT: issues 6 words in order:
  - 0x0C00 (shutdown)
  - 0x0F00 (test off)
  - {0x09, DECODE_MODE}
  - {0x0A, 4'h0, INIT_INTENSITY}
  - {0x0B, 5'h0, SCAN_LIMIT}
  - 0x0C01 (normal operation)
  - The first word is presented the first edge after reset release.
  - After the 6th ack: init_done=1 (sticky until reset), state=IDLE.
- IDLE (busy=0): timer increments each cycle, saturating at REFRESH_CYCLES. Each cycle, in priority order:
  1. int_pending -> state=INTENSITY.
  2. dirty or timer==REFRESH_CYCLES -> state=REFRESH, index=0, dirty cleared, timer cleared.
  3. Otherwise remain in IDLE.
  - The first word of the new state is presented on the same edge as the transition.
- INTENSITY:
  - Issues {0x0A, 4'h0, int_latched}, clears int_pending on ack, returns to IDLE.
  - Timer is not cleared.
- REFRESH:
  - Issues {4'h0, index+1, buffer[index]} for index 0..7.
  - The buffer byte is sampled when the word is registered.
  - After the 8th ack: timer=0, state=IDLE.
- Frame buffer writes:
  - Accepted every cycle in every state, including INIT.
  - A write sets dirty. A write on the same edge that REFRESH entry clears dirty wins: dirty stays 1.
  - A write during REFRESH therefore causes one further full refresh.
- int_wr:
  - Latches int_value into int_latched and sets int_pending, in any state.
  - Repeated strobes overwrite; the last value wins.
  - Within INIT the strobe is only recorded and acted on after INIT.
  - If int_wr coincides with the INTENSITY ack, the new value remains pending.
- Reset mid-operation (e.g. mid-REFRESH):
  - All state returns to reset values immediately; shift_valid drops asynchronously.
  - The full INIT sequence is rerun.
- Widths:
  - index is 3 bits.
  - timer is $clog2(REFRESH_CYCLES+1) bits and never wraps.

Test Plan:
- Reset release, shifter model acks 20 cycles after each valid -> exact word sequence 0C00, 0F00, 0900, 0A08, 0B07, 0C01, then 0100..0800 (all zero). init_done rises after the 6th ack.
- After init, write addr 2 data 0x5A -> one refresh of 8 words, the third word is 0x035A, then busy=0.
- With REFRESH_CYCLES=50 and no writes -> a new refresh starts exactly 50 cycles after the last refresh ack.
- int_wr value 3 during REFRESH index 4 -> refresh completes, then a single 0x0A03 word, then IDLE.
- Write addr 0 while REFRESH is on index 5 -> a second full refresh follows immediately, carrying the new byte in word 0x01xx.
- Assert reset_n low while shift_valid=1 mid-refresh -> shift_valid=0 immediately. After release, the sequence restarts at 0x0C00 with init_done=0.

Source files
------------

// File: rtl/max7219_refresh_ctrl_if.sv
// Application/shifter-facing signal bundle for max7219_refresh_ctrl.
// The master side is the controller; the slave side is its environment.
interface max7219_refresh_ctrl_if;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [7:0]  wr_data;
   logic        int_wr;
   logic [3:0]  int_value;
   logic [15:0] shift_data;
   logic        shift_valid;
   logic        shift_ack;
   logic        init_done;
   logic        busy;
   logic [1:0]  dbg_state;

   // shift_data/shift_valid are held until shift_ack is sampled high while
   // shift_valid=1; at most one word is outstanding, ack without valid is ignored.
   modport master (
      input  wr_en, wr_addr, wr_data, int_wr, int_value, shift_ack,
      output shift_data, shift_valid, init_done, busy, dbg_state
   );

   modport slave (
      output wr_en, wr_addr, wr_data, int_wr, int_value, shift_ack,
      input  shift_data, shift_valid, init_done, busy, dbg_state
   );
endinterface

// File: rtl/max7219_refresh_ctrl.sv
// MAX7219 sequencer: init words after reset, then refresh of 8 digit registers
// from a local frame buffer (on write or timer) and runtime intensity updates.
module max7219_refresh_ctrl #(
   parameter logic [7:0] DECODE_MODE    = 8'h00,
   parameter logic [3:0] INIT_INTENSITY = 4'h8,
   parameter logic [2:0] SCAN_LIMIT     = 3'd7,
   parameter int         REFRESH_CYCLES = 1000000
) (
   input  logic                   clock,
   input  logic                   reset_n,
   max7219_refresh_ctrl_if.master bus
);

   typedef enum logic [1:0] {
      S_INIT      = 2'd0,
      S_IDLE      = 2'd1,
      S_INTENSITY = 2'd2,
      S_REFRESH   = 2'd3
   } state_t;

   localparam int             TW   = $clog2(REFRESH_CYCLES + 1);
   localparam logic [TW-1:0]  RC_T = TW'(REFRESH_CYCLES);

   state_t        r_state, w_state_nx;
   logic [2:0]    r_index, w_index_nx, w_index_p1;
   logic [7:0]    r_fb [8];
   logic          r_dirty, w_dirty_nx;
   logic          r_int_pending, w_int_pending_nx;
   logic [3:0]    r_int_latched, w_int_eff;
   logic [TW-1:0] r_timer, w_timer_nx, w_timer_inc;
   logic [15:0]   r_shift_data, w_shift_data_nx;
   logic          r_shift_valid, w_shift_valid_nx;
   logic          r_init_done, w_init_done_nx;
   logic          w_ack;

   function automatic logic [15:0] init_word(input logic [2:0] i);
      case (i)
         3'd0:    init_word = 16'h0C00;
         3'd1:    init_word = 16'h0F00;
         3'd2:    init_word = {8'h09, DECODE_MODE};
         3'd3:    init_word = {8'h0A, 4'h0, INIT_INTENSITY};
         3'd4:    init_word = {8'h0B, 5'h00, SCAN_LIMIT};
         default: init_word = 16'h0C01;
      endcase
   endfunction

   function automatic logic [15:0] refresh_word(input logic [2:0] i, input logic [7:0] b);
      logic [3:0] a;
      a = {1'b0, i} + 4'd1;
      refresh_word = {4'h0, a, b};
   endfunction

   assign w_ack      = bus.shift_ack & r_shift_valid;
   assign w_index_p1 = r_index + 3'd1;
   // A strobe landing on the INTENSITY entry edge is sent directly, so it is never lost.
   assign w_int_eff  = bus.int_wr ? bus.int_value : r_int_latched;
   assign w_timer_inc = (r_timer == RC_T) ? r_timer : r_timer + TW'(1);

   always_comb begin
      w_state_nx       = r_state;
      w_index_nx       = r_index;
      w_dirty_nx       = r_dirty | bus.wr_en;
      w_int_pending_nx = r_int_pending | bus.int_wr;
      w_timer_nx       = r_timer;
      w_shift_data_nx  = r_shift_data;
      w_shift_valid_nx = r_shift_valid;
      w_init_done_nx   = r_init_done;
      case (r_state)
         S_INIT: begin
            if (!r_shift_valid) begin
               w_shift_data_nx  = init_word(r_index);
               w_shift_valid_nx = 1'b1;
            end else if (w_ack) begin
               if (r_index == 3'd5) begin
                  w_state_nx       = S_IDLE;
                  w_index_nx       = 3'd0;
                  w_shift_valid_nx = 1'b0;
                  w_init_done_nx   = 1'b1;
               end else begin
                  w_index_nx      = w_index_p1;
                  w_shift_data_nx = init_word(w_index_p1);
               end
            end
         end
         S_IDLE: begin
            // Comparing the incremented count makes the idle gap exactly REFRESH_CYCLES.
            w_timer_nx = w_timer_inc;
            if (r_int_pending) begin
               w_state_nx       = S_INTENSITY;
               w_shift_data_nx  = {8'h0A, 4'h0, w_int_eff};
               w_shift_valid_nx = 1'b1;
            end else if (r_dirty || (w_timer_inc == RC_T)) begin
               w_state_nx       = S_REFRESH;
               w_index_nx       = 3'd0;
               w_dirty_nx       = bus.wr_en;
               w_timer_nx       = '0;
               w_shift_data_nx  = refresh_word(3'd0, r_fb[0]);
               w_shift_valid_nx = 1'b1;
            end
         end
         S_INTENSITY: begin
            if (w_ack) begin
               w_state_nx       = S_IDLE;
               w_shift_valid_nx = 1'b0;
               w_int_pending_nx = bus.int_wr;
            end
         end
         S_REFRESH: begin
            if (w_ack) begin
               if (r_index == 3'd7) begin
                  w_state_nx       = S_IDLE;
                  w_index_nx       = 3'd0;
                  w_timer_nx       = '0;
                  w_shift_valid_nx = 1'b0;
               end else begin
                  w_index_nx      = w_index_p1;
                  w_shift_data_nx = refresh_word(w_index_p1, r_fb[w_index_p1]);
               end
            end
         end
         default: w_state_nx = S_INIT;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= S_INIT;
         r_index       <= 3'd0;
         r_dirty       <= 1'b1;
         r_int_pending <= 1'b0;
         r_int_latched <= 4'h0;
         r_timer       <= '0;
         r_shift_data  <= 16'h0000;
         r_shift_valid <= 1'b0;
         r_init_done   <= 1'b0;
      end else begin
         r_state       <= w_state_nx;
         r_index       <= w_index_nx;
         r_dirty       <= w_dirty_nx;
         r_int_pending <= w_int_pending_nx;
         r_timer       <= w_timer_nx;
         r_shift_data  <= w_shift_data_nx;
         r_shift_valid <= w_shift_valid_nx;
         r_init_done   <= w_init_done_nx;
         if (bus.int_wr) r_int_latched <= bus.int_value;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 8; i++) r_fb[i] <= 8'h00;
      end else if (bus.wr_en) begin
         r_fb[bus.wr_addr] <= bus.wr_data;
      end
   end

   assign bus.shift_data  = r_shift_data;
   assign bus.shift_valid = r_shift_valid;
   assign bus.init_done   = r_init_done;
   assign bus.busy        = (r_state != S_IDLE);
   assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_max7219_refresh_ctrl.sv
// Directed bench for max7219_refresh_ctrl: shifter model acks 20 cycles after
// each valid word; accepted words are compared against an expected queue.
module tb_max7219_refresh_ctrl;

   localparam int ACK_DLY = 20;

   logic clock;
   logic reset_n;
   max7219_refresh_ctrl_if bus ();

   max7219_refresh_ctrl #(
      .DECODE_MODE    (8'h00),
      .INIT_INTENSITY (4'h8),
      .SCAN_LIMIT     (3'd7),
      .REFRESH_CYCLES (50)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus.master)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // scoreboard state
   logic [15:0] exp_q[$];
   logic [15:0] got_q[$];
   logic [7:0]  exp_fb [8];
   int          n_vec = 0;
   int          n_err = 0;
   int          acks_since_reset = 0;
   int          init_at = -1;
   bit          init_seen = 1'b0;
   int          ack_cnt = 0;

   // shifter model: one-cycle ack ACK_DLY cycles after a word is presented
   always @(negedge clock) begin
      if (!reset_n) begin
         bus.shift_ack = 1'b0;
         ack_cnt = 0;
      end else if (bus.shift_ack) begin
         bus.shift_ack = 1'b0;
      end else if (bus.shift_valid) begin
         ack_cnt++;
         if (ack_cnt == ACK_DLY) begin
            bus.shift_ack = 1'b1;
            ack_cnt = 0;
         end
      end
   end

   // accepted-word recorder
   always @(posedge clock) begin
      if (reset_n && bus.shift_valid && bus.shift_ack) begin
         got_q.push_back(bus.shift_data);
         acks_since_reset++;
      end
   end

   always @(negedge clock or negedge reset_n) begin
      if (!reset_n) begin
         acks_since_reset = 0;
         init_seen = 1'b0;
         init_at = -1;
      end else if (bus.init_done && !init_seen) begin
         init_seen = 1'b1;
         init_at = acks_since_reset;
      end
   end

   // driver / checker tasks
   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] ref_word(input int i, input logic [7:0] b);
      logic [3:0] a;
      a = 4'(i + 1);
      ref_word = {4'h0, a, b};
   endfunction

   task automatic push_init();
      exp_q.push_back(16'h0C00);
      exp_q.push_back(16'h0F00);
      exp_q.push_back(16'h0900);
      exp_q.push_back(16'h0A08);
      exp_q.push_back(16'h0B07);
      exp_q.push_back(16'h0C01);
   endtask

   task automatic push_refresh();
      for (int i = 0; i < 8; i++) exp_q.push_back(ref_word(i, exp_fb[i]));
   endtask

   task automatic wait_words(input string tag, input int n, input int budget);
      int k;
      k = 0;
      while (got_q.size() < n && k < budget) begin
         @(negedge clock);
         k++;
      end
      check({tag, "_word_count_reached"}, 16'(got_q.size() >= n), 16'd1);
   endtask

   task automatic compare_words(input string tag);
      int idx;
      logic [15:0] e;
      logic [15:0] g;
      idx = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : 16'hxxxx;
         check($sformatf("%s_w%0d", tag, idx), g, e);
         idx++;
      end
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int k;
      k = 0;
      while (bus.busy !== 1'b0 && k < budget) begin
         @(negedge clock);
         k++;
      end
      check({tag, "_idle"}, {15'd0, bus.busy}, 16'd0);
   endtask

   task automatic wait_presented(input string tag, input logic [3:0] reg_addr, input int budget);
      int k;
      k = 0;
      while (!(bus.shift_valid === 1'b1 && bus.shift_data[11:8] === reg_addr) && k < budget) begin
         @(negedge clock);
         k++;
      end
      check({tag, "_presented"}, {12'd0, bus.shift_data[11:8]}, {12'd0, reg_addr});
   endtask

   task automatic write_fb(input logic [2:0] a, input logic [7:0] d);
      bus.wr_en = 1'b1;
      bus.wr_addr = a;
      bus.wr_data = d;
      @(negedge clock);
      bus.wr_en = 1'b0;
      exp_fb[a] = d;
   endtask

   // directed sequence
   initial begin
      int idle_cnt;
      reset_n = 1'b0;
      bus.wr_en = 1'b0;
      bus.wr_addr = 3'd0;
      bus.wr_data = 8'h00;
      bus.int_wr = 1'b0;
      bus.int_value = 4'h0;
      bus.shift_ack = 1'b0;
      for (int i = 0; i < 8; i++) exp_fb[i] = 8'h00;
      repeat (3) @(negedge clock);

      check("rst_valid", {15'd0, bus.shift_valid}, 16'd0);
      check("rst_data", bus.shift_data, 16'h0000);
      check("rst_init_done", {15'd0, bus.init_done}, 16'd0);
      check("rst_busy", {15'd0, bus.busy}, 16'd1);

      // init sequence then the first (all-zero) refresh
      reset_n = 1'b1;
      @(negedge clock);
      check("first_word_valid", {15'd0, bus.shift_valid}, 16'd1);
      check("first_word_data", bus.shift_data, 16'h0C00);
      push_init();
      push_refresh();
      wait_words("init", 14, 1000);
      compare_words("init");
      check("init_done_after_ack", 16'(init_at), 16'd6);
      wait_idle("init", 50);
      check("init_idle_valid", {15'd0, bus.shift_valid}, 16'd0);

      // buffer write triggers one refresh carrying the new byte
      write_fb(3'd2, 8'h5A);
      push_refresh();
      wait_words("wr", 8, 500);
      compare_words("wr");
      wait_idle("wr", 50);

      // timer-forced refresh: idle gap must be exactly REFRESH_CYCLES
      idle_cnt = 0;
      while (bus.busy === 1'b0 && idle_cnt < 500) begin
         idle_cnt++;
         @(negedge clock);
      end
      check("timer_idle_gap", 16'(idle_cnt), 16'd50);

      // intensity strobe at refresh index 4 waits until the refresh ends
      push_refresh();
      exp_q.push_back(16'h0A03);
      wait_presented("int", 4'h5, 200);
      bus.int_wr = 1'b1;
      bus.int_value = 4'h3;
      @(negedge clock);
      bus.int_wr = 1'b0;
      wait_words("int", 9, 500);
      compare_words("int");
      wait_idle("int", 50);
      check("int_no_extra_word", 16'(got_q.size()), 16'd0);

      // write during refresh index 5 forces a second full refresh
      push_refresh();
      wait_presented("wr_mid", 4'h6, 500);
      write_fb(3'd0, 8'hC3);
      push_refresh();
      wait_words("wr_mid", 16, 1000);
      compare_words("wr_mid");
      wait_idle("wr_mid", 50);

      // reset mid-refresh
      write_fb(3'd7, 8'h81);
      wait_presented("rst_mid", 4'h4, 300);
      reset_n = 1'b0;
      #1;
      check("rst_mid_valid", {15'd0, bus.shift_valid}, 16'd0);
      check("rst_mid_data", bus.shift_data, 16'h0000);
      check("rst_mid_init_done", {15'd0, bus.init_done}, 16'd0);
      check("rst_mid_busy", {15'd0, bus.busy}, 16'd1);
      got_q.delete();
      for (int i = 0; i < 8; i++) exp_fb[i] = 8'h00;
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      check("rerun_first_word", bus.shift_data, 16'h0C00);
      check("rerun_init_done", {15'd0, bus.init_done}, 16'd0);
      push_init();
      push_refresh();
      wait_words("rerun", 14, 1000);
      compare_words("rerun");
      check("rerun_init_done_after_ack", 16'(init_at), 16'd6);
      wait_idle("rerun", 50);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
